// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
//   MODE_FIXED / MODE_RR : encodings of the mode input.
//   clog2_min1           : ceil(log2(n)) clamped to at least 1, so that
//                          channel index fields are never zero-width.
package stream_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Grants the first asserted request at or after (ptr+1) mod N_IN, wrapping
// from N_IN-1 back to 0. ptr is the index of the last served requester.
//   req       in  N_IN   request vector
//   ptr       in  SEL_W  last granted index (must be < N_IN)
//   gnt_idx   out SEL_W  granted index (0 when gnt_valid is low)
//   gnt_valid out 1      a request was granted
module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int SEL_W = clog2_min1(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    int w_k;

    // Scan from the farthest candidate to the nearest so the last hit,
    // which overrides earlier ones, is the highest-priority requester.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        w_k       = 0;
        for (int i = N_IN; i >= 1; i--) begin
            w_k = (int'(ptr) + i) % N_IN;
            if (req[w_k]) begin
                gnt_idx   = SEL_W'(w_k);
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-to-1 valid/ready stream multiplexer with a registered output.
// Selection is either fixed (sel) or round-robin; the round-robin pointer
// tracks the last served channel in both modes.
//   clk, rst_n          clock, async active-low reset
//   in_data/in_valid    per-channel input streams (channel k at [k*WIDTH +: WIDTH])
//   in_ready            per-channel ready, combinational, at most one bit high
//   mode, sel           0 = fixed select on sel, 1 = round-robin
//   out_data/out_valid  registered output stream, out_ready from downstream
//   out_ch              index of the channel that sourced out_data
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter  int N_IN  = 4,
    parameter  int WIDTH = 8,
    localparam int SEL_W = clog2_min1(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      out_ch
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic [SEL_W-1:0] r_ch;
    logic [SEL_W-1:0] r_ptr;

    logic             w_load_en;
    logic             w_fix_valid;
    logic             w_rr_valid;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_gnt_valid;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_gnt_data;

    rr_arbiter #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (r_ptr),
        .gnt_idx   (w_rr_idx),
        .gnt_valid (w_rr_valid)
    );

    assign w_load_en = ~r_valid | out_ready;

    always_comb begin
        // An out-of-range sel matches no channel, so it simply never grants.
        w_fix_valid = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                w_fix_valid = in_valid[k];
            end
        end

        if (mode == MODE_RR) begin
            w_gnt_valid = w_rr_valid;
            w_gnt_idx   = w_rr_idx;
        end else begin
            w_gnt_valid = w_fix_valid;
            w_gnt_idx   = w_fix_valid ? sel : '0;
        end

        // rst_n gates ready so nothing handshakes while the block is held in reset.
        w_xfer = rst_n & w_load_en & w_gnt_valid;

        w_gnt_data = '0;
        in_ready   = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (w_gnt_idx == SEL_W'(k)) begin
                w_gnt_data  = in_data[k*WIDTH +: WIDTH];
                in_ready[k] = w_xfer;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_ptr   <= SEL_W'(N_IN - 1);
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_gnt_data;
            r_ch    <= w_gnt_idx;
            r_ptr   <= w_gnt_idx;
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_ch    = r_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

    logic        clk;
    logic        rst_n;

    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic        mode;
    logic [1:0]  sel;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ch;

    logic [23:0] in_data3;
    logic [2:0]  in_valid3;
    logic [2:0]  in_ready3;
    logic        mode3;
    logic [1:0]  sel3;
    logic [7:0]  out_data3;
    logic        out_valid3;
    logic        out_ready3;
    logic [1:0]  out_ch3;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] D_DEF = 32'h4433_2211;

    stream_mux_rr #(.N_IN(4), .WIDTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sel       (sel),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch)
    );

    stream_mux_rr #(.N_IN(3), .WIDTH(8)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .sel       (sel3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_ch    (out_ch3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check in_ready before the edge, then the registered outputs after it.
    task automatic cyc(input string tag, input logic [3:0] rdy, input logic v,
                       input logic [1:0] ch, input logic [7:0] d);
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".out_ch"}, 32'(out_ch), 32'(ch));
        chk({tag, ".out_data"}, 32'(out_data), 32'(d));
    endtask

    initial begin
        rst_n      = 1'b0;
        in_data    = D_DEF;
        in_valid   = 4'b1111;
        mode       = 1'b1;
        sel        = 2'd0;
        out_ready  = 1'b1;
        in_data3   = 24'h77_6655;
        in_valid3  = 3'b000;
        mode3      = 1'b0;
        sel3       = 2'd0;
        out_ready3 = 1'b1;

        #2;
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data", 32'(out_data), 32'd0);
        chk("rst.out_ch", 32'(out_ch), 32'd0);
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: round-robin, all valid
        cyc("t1.0", 4'b0001, 1'b1, 2'd0, 8'h11);
        cyc("t1.1", 4'b0010, 1'b1, 2'd1, 8'h22);
        cyc("t1.2", 4'b0100, 1'b1, 2'd2, 8'h33);
        cyc("t1.3", 4'b1000, 1'b1, 2'd3, 8'h44);
        cyc("t1.4", 4'b0001, 1'b1, 2'd0, 8'h11);
        cyc("t1.5", 4'b0010, 1'b1, 2'd1, 8'h22);

        // 2: only channels 1 and 3 valid, last served was ch1
        in_valid = 4'b1010;
        cyc("t2.0", 4'b1000, 1'b1, 2'd3, 8'h44);
        cyc("t2.1", 4'b0010, 1'b1, 2'd1, 8'h22);
        cyc("t2.2", 4'b1000, 1'b1, 2'd3, 8'h44);
        cyc("t2.3", 4'b0010, 1'b1, 2'd1, 8'h22);

        // 3: ch2 word A5 then backpressure for three cycles
        in_valid = 4'b0100;
        in_data  = 32'h44A5_2211;
        cyc("t3.load", 4'b0100, 1'b1, 2'd2, 8'hA5);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        cyc("t3.bp0", 4'b0000, 1'b1, 2'd2, 8'hA5);
        cyc("t3.bp1", 4'b0000, 1'b1, 2'd2, 8'hA5);
        cyc("t3.bp2", 4'b0000, 1'b1, 2'd2, 8'hA5);
        out_ready = 1'b1;
        cyc("t3.resume", 4'b1000, 1'b1, 2'd3, 8'h44);

        // 4: fixed select on ch2, then sel=3 with ch3 idle
        in_data = D_DEF;
        mode    = 1'b0;
        sel     = 2'd2;
        cyc("t4.fix0", 4'b0100, 1'b1, 2'd2, 8'h33);
        cyc("t4.fix1", 4'b0100, 1'b1, 2'd2, 8'h33);
        cyc("t4.fix2", 4'b0100, 1'b1, 2'd2, 8'h33);
        sel      = 2'd3;
        in_valid = 4'b0111;
        cyc("t4.drain", 4'b0000, 1'b0, 2'd2, 8'h33);
        cyc("t4.idle", 4'b0000, 1'b0, 2'd2, 8'h33);

        // 4b: three-channel instance, sel=3 is out of range
        chk("t4b.idle_valid", 32'(out_valid3), 32'd0);
        mode3     = 1'b0;
        sel3      = 2'd3;
        in_valid3 = 3'b111;
        repeat (2) begin
            #1;
            chk("t4b.oor_ready", 32'(in_ready3), 32'd0);
            @(posedge clk);
            #1;
            chk("t4b.oor_valid", 32'(out_valid3), 32'd0);
        end
        sel3 = 2'd2;
        #1;
        chk("t4b.sel2_ready", 32'(in_ready3), 32'b100);
        @(posedge clk);
        #1;
        chk("t4b.sel2_valid", 32'(out_valid3), 32'd1);
        chk("t4b.sel2_ch", 32'(out_ch3), 32'd2);
        chk("t4b.sel2_data", 32'(out_data3), 32'h77);

        // 5: serve ch1 in fixed mode, then switch to round-robin
        in_valid = 4'b1111;
        sel      = 2'd1;
        cyc("t5.fix", 4'b0010, 1'b1, 2'd1, 8'h22);
        mode = 1'b1;
        cyc("t5.rr0", 4'b0100, 1'b1, 2'd2, 8'h33);
        cyc("t5.rr1", 4'b1000, 1'b1, 2'd3, 8'h44);
        cyc("t5.rr2", 4'b0001, 1'b1, 2'd0, 8'h11);
        cyc("t5.rr3", 4'b0010, 1'b1, 2'd1, 8'h22);

        // 6: async reset while holding a word under backpressure
        out_ready = 1'b0;
        cyc("t6.hold", 4'b0000, 1'b1, 2'd1, 8'h22);
        rst_n = 1'b0;
        #1;
        chk("t6.rst_valid", 32'(out_valid), 32'd0);
        chk("t6.rst_data", 32'(out_data), 32'd0);
        chk("t6.rst_ch", 32'(out_ch), 32'd0);
        chk("t6.rst_ready", 32'(in_ready), 32'd0);
        #4;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        cyc("t6.first", 4'b0001, 1'b1, 2'd0, 8'h11);
        cyc("t6.second", 4'b0010, 1'b1, 2'd1, 8'h22);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-to-1 stream multiplexer with valid/ready handshakes on every input and on the output.
- Successor to the combinational 2:1 mux.
- Selection runs in one of two modes, fixed from the external `sel` or round-robin, and the output is registered.
- Merges several producer streams into one consumer, for example shared bus ports and debug/trace funnels.

Parameters:
- N_IN, 4, number of input channels; legal range 2 to 16.
- WIDTH, 8, data bits per channel; minimum 1.
- SEL_W, derived localparam = max(1, $clog2(N_IN)), width of `sel` and `out_ch`; not overridable.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_data  in  N_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  in  N_IN  per-channel valid.
- in_ready  out  N_IN  per-channel ready; combinational; at most one bit high.
- mode  in  1  0 = fixed select, 1 = round-robin.
- sel  in  SEL_W  channel index used in fixed mode.
- out_data  out  WIDTH  registered output data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  downstream ready.
- out_ch  out  SEL_W  index of the channel that sourced out_data.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - out_valid = 0, out_data = 0, out_ch = 0.
  - rr_ptr = N_IN-1, so channel 0 has first priority after reset.
  - in_ready = 0 while rst_n is low.
- load_en = ~out_valid | out_ready. The output register accepts a new word only when load_en is high.
- Grant, combinational:
  - mode = 0: grant = sel, provided sel < N_IN and in_valid[sel]. Otherwise there is no grant. An out-of-range sel never grants and never errors.
  - mode = 1: grant = the first k with in_valid[k] high, searching from (rr_ptr+1) mod N_IN upward and wrapping past N_IN-1 to 0. If no valid is set, there is no grant.
- in_ready[g] = load_en & grant_valid & (g == grant). A transfer on channel g is in_valid[g] & in_ready[g].
- On a transfer, in the same clock edge:
  - out_data <= channel g data, out_ch <= g, out_valid <= 1.
  - rr_ptr <= g. The pointer updates in both modes, so switching to round-robin resumes fairly after the last served channel.
- When out_valid & out_ready and no transfer occurs, out_valid <= 0; out_data and out_ch hold their values.
- Latency and throughput:
  - Latency is 1 cycle from input handshake to out_valid.
  - Throughput is one word per cycle while out_ready stays high, because load_en is high.
- Backpressure: while out_valid & ~out_ready, out_data, out_ch and out_valid stay stable. All in_ready bits are 0 and rr_ptr holds.
- Simultaneous drain and refill: when out_ready is high and an input transfers in the same cycle, the new word replaces the old one with no bubble.
- Mode or sel changes take effect on the next grant evaluation. They never alter a word already in the output register.
- Fairness: with all N_IN channels continuously valid in mode 1, each channel is served exactly once per N_IN transfers.
- Reset asserted mid-stream drops the held word immediately (out_valid = 0). No partial state survives.

Decomposition:
- Shared package `stream_mux_pkg`:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1.
  - Function `clog2_min1` for deriving SEL_W.
- One sub-module, `rr_arbiter`:
  - Purely combinational.
  - Inputs: req[N_IN], ptr[SEL_W]. Outputs: gnt_idx[SEL_W], gnt_valid.
  - Reusable by other arbitrated blocks.
- The top-level module holds the fixed/round-robin select, the output register and rr_ptr.

Test Plan:
1. Reset, then mode=1, all four valids high, out_ready=1 → out_ch sequence 0,1,2,3,0,1; out_valid high every cycle from cycle 1; data matches source.
2. mode=1, only channels 1 and 3 valid, out_ready=1 → out_ch alternates 1,3,1,3; in_ready[0] and in_ready[2] never high.
3. mode=1, ch2 word 0xA5 granted, then out_ready=0 for 3 cycles → out_data=0xA5, out_ch=2 stable; in_ready=0000; then out_ready=1 → next grant is ch3 (if valid).
4. mode=0, sel=2, all valids high → only ch2 is ever served. Then sel=3 (N_IN=4) with in_valid[3]=0 → no transfer, out_valid falls after drain. Repeat with N_IN=3, sel=3 → never grants.
5. mode=0 serving ch1, switch mode to 1 with all valids high → next grants are 2,3,0,1.
6. Assert rst_n low for half a cycle while out_valid=1 and out_ready=0 → out_valid, out_data and out_ch go to 0 immediately, without waiting for a clock edge. After release, the first round-robin grant is ch0.
